regfile_hazard_ctrl: RTL and testbench

Controller that sequences the 16x32 register file in the pipeline.
- After reset it runs an init sweep that writes INIT_VALUE into every register.
- It then tracks destination tags through the EX, MEM and WB stages.
- It drives the register-file write port from the WB tag.
- It generates per-read-port forwarding selects and a load-use stall for decode.

---
 rtl/regfile_hazard_ctrl_pkg.sv | 35 +++
 rtl/regfile_hazard_ctrl_stage_tag.sv | 23 ++
 rtl/regfile_hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_regfile_hazard_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_hazard_ctrl_pkg.sv
// Shared types and constants for the register-file hazard controller:
// opcode, forwarding-select encoding, pipeline stage tag and FSM states.
package regfile_hazard_ctrl_pkg;

    localparam int IDX_W = 4;

    localparam logic [3:0] OP1_LW = 4'b1001;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] rd;
        logic             wr;
        logic             isLoad;
    } stage_tag_t;

    localparam int TAG_W = $bits(stage_tag_t);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } ctrl_state_t;

    // A stage can feed a read port only if it will actually write that index.
    function automatic logic tagMatch(input stage_tag_t t,
                                      input logic [IDX_W-1:0] rs,
                                      input logic useRs);
        return t.valid & t.wr & (t.rd == rs) & useRs;
    endfunction

endpackage

// File: rtl/regfile_hazard_ctrl_stage_tag.sv
// One pipeline stage of destination-tag tracking; a bubble or reset
// leaves an all-zero (invalid) tag.
module regfile_stage_tag
    import regfile_hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             bubble,
    input  logic [TAG_W-1:0] tagIn,
    output logic [TAG_W-1:0] tagOut
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tagOut <= '0;
        end else if (bubble) begin
            tagOut <= '0;
        end else begin
            tagOut <= tagIn;
        end
    end

endmodule

// File: rtl/regfile_hazard_ctrl.sv
// Register-file controller: init sweep after reset, then EX/MEM/WB tag
// tracking that drives the write port, forwarding selects and load-use stall.
module regfile_hazard_ctrl #(
    parameter int                        INDEX_BIT_WIDTH = 4,
    parameter int                        DATA_BIT_WIDTH  = 32,
    parameter int                        N_REGS          = 1 << INDEX_BIT_WIDTH,
    parameter logic [3:0]                OP1_LW          = regfile_hazard_ctrl_pkg::OP1_LW,
    parameter logic [DATA_BIT_WIDTH-1:0] INIT_VALUE      = '0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       dec_valid,
    input  logic [3:0]                 dec_opcode,
    input  logic [INDEX_BIT_WIDTH-1:0] dec_rs1,
    input  logic [INDEX_BIT_WIDTH-1:0] dec_rs2,
    input  logic                       dec_use1,
    input  logic                       dec_use2,
    input  logic [INDEX_BIT_WIDTH-1:0] dec_rd,
    input  logic                       dec_wr,
    input  logic                       flush,
    input  logic [DATA_BIT_WIDTH-1:0]  wb_data,
    output logic                       stall,
    output logic                       init_busy,
    output logic [1:0]                 fwd_sel1,
    output logic [1:0]                 fwd_sel2,
    output logic                       rf_wrtEn,
    output logic [INDEX_BIT_WIDTH-1:0] rf_wrtIndex,
    output logic [DATA_BIT_WIDTH-1:0]  rf_dataIn
);

    import regfile_hazard_ctrl_pkg::*;

    ctrl_state_t                state, stateNext;
    logic [INDEX_BIT_WIDTH-1:0] initCount;
    stage_tag_t                 decTag, exTag, memTag, wbTag;
    logic                       inInit, loadUse;
    logic                       exBubble, memBubble;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_INIT;
            initCount <= '0;
        end else begin
            state <= stateNext;
            if (state == ST_INIT) begin
                initCount <= initCount + 1'b1;
            end
        end
    end

    always_comb begin
        stateNext = state;
        if (state == ST_INIT && initCount == INDEX_BIT_WIDTH'(N_REGS - 1)) begin
            stateNext = ST_RUN;
        end
    end

    assign inInit = (state == ST_INIT);

    always_comb begin
        decTag        = '0;
        decTag.valid  = 1'b1;
        decTag.rd     = dec_rd;
        decTag.wr     = dec_wr;
        decTag.isLoad = (dec_opcode == OP1_LW);
    end

    assign loadUse = exTag.isLoad &
                     (tagMatch(exTag, dec_rs1, dec_use1) | tagMatch(exTag, dec_rs2, dec_use2));

    // Flush overrides the load-use hold: the dependent instruction is dead anyway.
    assign stall     = inInit | (dec_valid & ~flush & loadUse);
    assign exBubble  = inInit | ~dec_valid | stall | flush;
    assign memBubble = inInit | flush;

    regfile_stage_tag uExTag (
        .clk    (clk),
        .reset_n(reset_n),
        .bubble (exBubble),
        .tagIn  (decTag),
        .tagOut (exTag)
    );

    regfile_stage_tag uMemTag (
        .clk    (clk),
        .reset_n(reset_n),
        .bubble (memBubble),
        .tagIn  (exTag),
        .tagOut (memTag)
    );

    regfile_stage_tag uWbTag (
        .clk    (clk),
        .reset_n(reset_n),
        .bubble (inInit),
        .tagIn  (memTag),
        .tagOut (wbTag)
    );

    // A load in EX has no result yet, so it yields to older writers (the stall covers it).
    function automatic logic [1:0] fwdSelect(input stage_tag_t exT,
                                             input stage_tag_t memT,
                                             input stage_tag_t wbT,
                                             input logic [IDX_W-1:0] rs,
                                             input logic useRs);
        if (tagMatch(exT, rs, useRs) && !exT.isLoad) begin
            return FWD_EX;
        end else if (tagMatch(memT, rs, useRs)) begin
            return FWD_MEM;
        end else if (tagMatch(wbT, rs, useRs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    always_comb begin
        fwd_sel1    = fwdSelect(exTag, memTag, wbTag, dec_rs1, dec_use1);
        fwd_sel2    = fwdSelect(exTag, memTag, wbTag, dec_rs2, dec_use2);
        init_busy   = inInit;
        rf_wrtEn    = wbTag.valid & wbTag.wr;
        rf_wrtIndex = wbTag.rd;
        rf_dataIn   = wb_data;
        if (inInit) begin
            rf_wrtEn    = 1'b1;
            rf_wrtIndex = initCount;
            rf_dataIn   = INIT_VALUE;
        end
    end

endmodule

// File: tb/tb_regfile_hazard_ctrl.sv
// Self-checking bench for regfile_hazard_ctrl: init sweep, forwarding,
// load-use stall, flush and reset scenarios with a write-port scoreboard.
module tb_regfile_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dec_valid;
    logic [3:0]  dec_opcode;
    logic [3:0]  dec_rs1;
    logic [3:0]  dec_rs2;
    logic        dec_use1;
    logic        dec_use2;
    logic [3:0]  dec_rd;
    logic        dec_wr;
    logic        flush;
    logic [31:0] wb_data;
    logic        stall;
    logic        init_busy;
    logic [1:0]  fwd_sel1;
    logic [1:0]  fwd_sel2;
    logic        rf_wrtEn;
    logic [3:0]  rf_wrtIndex;
    logic [31:0] rf_dataIn;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_LW  = 4'b1001;

    regfile_hazard_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .dec_valid  (dec_valid),
        .dec_opcode (dec_opcode),
        .dec_rs1    (dec_rs1),
        .dec_rs2    (dec_rs2),
        .dec_use1   (dec_use1),
        .dec_use2   (dec_use2),
        .dec_rd     (dec_rd),
        .dec_wr     (dec_wr),
        .flush      (flush),
        .wb_data    (wb_data),
        .stall      (stall),
        .init_busy  (init_busy),
        .fwd_sel1   (fwd_sel1),
        .fwd_sel2   (fwd_sel2),
        .rf_wrtEn   (rf_wrtEn),
        .rf_wrtIndex(rf_wrtIndex),
        .rf_dataIn  (rf_dataIn)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errCount   = 0;
    int checkCount = 0;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] data;
    } wr_exp_t;

    wr_exp_t sbQ[$];

    task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Write-port scoreboard: every RUN-mode write must match the oldest expected one.
    always @(negedge clk) begin
        wr_exp_t e;
        #2;
        if (reset_n && !init_busy && rf_wrtEn) begin
            if (sbQ.size() == 0) begin
                checkEq("unexpectedWr", 32'(rf_wrtEn), 32'd0);
            end else begin
                e = sbQ.pop_front();
                checkEq("wrIdx", 32'(rf_wrtIndex), 32'(e.idx));
                checkEq("wrData", rf_dataIn, e.data);
            end
        end
    end

    task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] rs1,
                         input logic [3:0] rs2, input logic u1, input logic u2,
                         input logic [3:0] rd, input logic wr, input logic fl);
        @(negedge clk);
        dec_valid  = v;
        dec_opcode = op;
        dec_rs1    = rs1;
        dec_rs2    = rs2;
        dec_use1   = u1;
        dec_use2   = u2;
        dec_rd     = rd;
        dec_wr     = wr;
        flush      = fl;
        wb_data    = {16'hA5A5, cyc[15:0]};
        #1;
    endtask

    task automatic idle();
        drive(1'b0, OP_ADD, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    // Accepted now, so its result reaches WB three cycles later.
    task automatic expectWrite(input logic [3:0] rd);
        logic [15:0] wcyc;
        wcyc = cyc[15:0] + 16'd3;
        sbQ.push_back('{idx: rd, data: {16'hA5A5, wcyc}});
    endtask

    task automatic releaseAndSweep(input int stopAt);
        @(negedge clk);
        dec_valid = 1'b0;
        flush     = 1'b0;
        reset_n   = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            checkEq("initIdx", 32'(rf_wrtIndex), 32'(i));
            checkEq("initEn", 32'(rf_wrtEn), 32'd1);
            checkEq("initData", rf_dataIn, 32'd0);
            checkEq("initBusy", 32'(init_busy), 32'd1);
            checkEq("initStall", 32'(stall), 32'd1);
            if (i == stopAt) return;
        end
        @(negedge clk);
        #1;
        checkEq("runBusy", 32'(init_busy), 32'd0);
        checkEq("runStall", 32'(stall), 32'd0);
        checkEq("runWrEn", 32'(rf_wrtEn), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        dec_valid  = 1'b0;
        dec_opcode = OP_ADD;
        dec_rs1    = '0;
        dec_rs2    = '0;
        dec_use1   = 1'b0;
        dec_use2   = 1'b0;
        dec_rd     = '0;
        dec_wr     = 1'b0;
        flush      = 1'b0;
        wb_data    = '0;
        repeat (2) @(negedge clk);
        #1;
        checkEq("rstBusy", 32'(init_busy), 32'd1);
        checkEq("rstStall", 32'(stall), 32'd1);
        checkEq("rstWrEn", 32'(rf_wrtEn), 32'd1);
        checkEq("rstIdx", 32'(rf_wrtIndex), 32'd0);
        checkEq("rstFwd1", 32'(fwd_sel1), 32'd0);
        checkEq("rstFwd2", 32'(fwd_sel2), 32'd0);

        // Reset pulsed mid-sweep at index 9, then a full sweep.
        releaseAndSweep(9);
        reset_n = 1'b0;
        #1;
        checkEq("midRstIdx", 32'(rf_wrtIndex), 32'd0);
        checkEq("midRstBusy", 32'(init_busy), 32'd1);
        releaseAndSweep(16);

        // ADD r3 ; ADD r5,r3,r3
        idle();
        drive(1'b1, OP_ADD, 4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
        checkEq("s1aStall", 32'(stall), 32'd0);
        checkEq("s1aFwd1", 32'(fwd_sel1), 32'd0);
        expectWrite(4'd3);
        drive(1'b1, OP_ADD, 4'd3, 4'd3, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0);
        checkEq("s1bStall", 32'(stall), 32'd0);
        checkEq("s1bFwd1", 32'(fwd_sel1), 32'd1);
        checkEq("s1bFwd2", 32'(fwd_sel2), 32'd1);
        expectWrite(4'd5);
        repeat (3) idle();

        // LW r4 ; ADD r6,r4,r1 -> one bubble, then MEM forward
        drive(1'b1, OP_LW, 4'd1, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0);
        expectWrite(4'd4);
        drive(1'b1, OP_ADD, 4'd4, 4'd1, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0);
        checkEq("s2Stall", 32'(stall), 32'd1);
        drive(1'b1, OP_ADD, 4'd4, 4'd1, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0);
        checkEq("s2StallOnce", 32'(stall), 32'd0);
        checkEq("s2Fwd1", 32'(fwd_sel1), 32'd2);
        checkEq("s2Fwd2", 32'(fwd_sel2), 32'd0);
        expectWrite(4'd6);
        repeat (3) idle();

        // LW r4 followed by no valid instruction: no stall
        drive(1'b1, OP_LW, 4'd1, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0);
        expectWrite(4'd4);
        drive(1'b0, OP_ADD, 4'd4, 4'd4, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        checkEq("noValidStall", 32'(stall), 32'd0);
        repeat (2) idle();

        // r7 writer, two unrelated, then reader: WB forward alongside the write
        drive(1'b1, OP_ADD, 4'd10, 4'd11, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0);
        expectWrite(4'd7);
        drive(1'b1, OP_ADD, 4'd10, 4'd11, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0);
        expectWrite(4'd8);
        drive(1'b1, OP_ADD, 4'd10, 4'd11, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0);
        expectWrite(4'd9);
        drive(1'b1, OP_ADD, 4'd7, 4'd8, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        checkEq("s3Fwd1", 32'(fwd_sel1), 32'd3);
        checkEq("s3Fwd2", 32'(fwd_sel2), 32'd2);
        checkEq("s3WrEn", 32'(rf_wrtEn), 32'd1);
        checkEq("s3WrIdx", 32'(rf_wrtIndex), 32'd7);
        checkEq("s3WrData", rf_dataIn, wb_data);
        repeat (3) idle();

        // r2 in EX and MEM: youngest wins; unused rs2 does not forward
        drive(1'b1, OP_ADD, 4'd1, 4'd1, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0);
        expectWrite(4'd2);
        drive(1'b1, OP_ADD, 4'd1, 4'd1, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0);
        expectWrite(4'd2);
        drive(1'b1, OP_ADD, 4'd2, 4'd2, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        checkEq("s4Fwd1", 32'(fwd_sel1), 32'd1);
        checkEq("s4Fwd2Unused", 32'(fwd_sel2), 32'd0);
        repeat (3) idle();

        // Flush with LW r4 in EX and a dependent in decode
        drive(1'b1, OP_LW, 4'd1, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0);
        drive(1'b1, OP_ADD, 4'd4, 4'd1, 1'b1, 1'b1, 4'd6, 1'b1, 1'b1);
        checkEq("flushStall", 32'(stall), 32'd0);
        for (int i = 0; i < 3; i++) begin
            idle();
            checkEq("flushNoWr", 32'(rf_wrtEn), 32'd0);
        end

        // Reset during RUN with live tags: nothing stale may be written
        drive(1'b1, OP_ADD, 4'd1, 4'd1, 1'b1, 1'b1, 4'd12, 1'b1, 1'b0);
        drive(1'b1, OP_ADD, 4'd1, 4'd1, 1'b1, 1'b1, 4'd13, 1'b1, 1'b0);
        @(negedge clk);
        reset_n  = 1'b0;
        dec_rs1  = 4'd12;
        dec_use1 = 1'b1;
        #1;
        checkEq("runRstBusy", 32'(init_busy), 32'd1);
        checkEq("runRstIdx", 32'(rf_wrtIndex), 32'd0);
        checkEq("runRstFwd1", 32'(fwd_sel1), 32'd0);
        sbQ.delete();
        releaseAndSweep(16);
        for (int i = 0; i < 4; i++) begin
            idle();
            checkEq("postRstNoWr", 32'(rf_wrtEn), 32'd0);
        end

        checkEq("sbDrained", 32'(sbQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
